// File: rtl/add_round_key_stream.sv
// Streaming AES AddRoundKey stage: local round-key file, one XOR per accepted block,
// and a 2-entry output FIFO so downstream back-pressure never loses a block.
`timescale 1ns/1ps
module add_round_key_stream #(
    parameter int DATA_W = 128,
    parameter int NKEYS  = 15,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr_en,
    input  logic [IDX_W-1:0]  key_wr_addr,
    input  logic [DATA_W-1:0] key_wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_state,
    input  logic [IDX_W-1:0]  in_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_state,
    output logic              out_err,
    output logic [CNT_W-1:0]  blk_cnt
);

    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic logic [DATA_W-1:0] xor_bytes(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++) begin
            r[i*8 +: 8] = a[i*8 +: 8] ^ b[i*8 +: 8];
        end
        return r;
    endfunction

    logic [DATA_W-1:0] keys_q [NKEYS];
    logic [DATA_W-1:0] keys_d [NKEYS];

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
    logic              head_err_q, head_err_d, tail_err_q, tail_err_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

    logic              push_s, pop_s;
    logic              wr_ok_s, round_ok_s;
    logic [DATA_W-1:0] key_sel_s, result_s;

    assign push_s  = in_valid & in_ready_q;
    assign pop_s   = out_valid_q & out_ready;
    assign wr_ok_s = ({{(32-IDX_W){1'b0}}, key_wr_addr} < 32'(NKEYS));

    // Key file update; reads below use keys_q, so a same-cycle write is seen only by later blocks.
    always_comb begin
        keys_d = keys_q;
        if (key_wr_en && wr_ok_s) begin
            keys_d[key_wr_addr] = key_wr_data;
        end else begin
            keys_d = keys_q;
        end
    end

    // Key selection and XOR; an out-of-range round passes the state through unchanged.
    always_comb begin
        round_ok_s = ({{(32-IDX_W){1'b0}}, in_round} < 32'(NKEYS));
        if (round_ok_s) begin
            key_sel_s = keys_q[in_round];
        end else begin
            key_sel_s = '0;
        end
        result_s = xor_bytes(in_state, key_sel_s);
    end

    // Buffer occupancy next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push_s) state_d = BUF_ONE;
                else        state_d = BUF_EMPTY;
            end
            BUF_ONE: begin
                if (push_s && !pop_s)      state_d = BUF_FULL;
                else if (!push_s && pop_s) state_d = BUF_EMPTY;
                else                       state_d = BUF_ONE;
            end
            BUF_FULL: begin
                if (pop_s) state_d = BUF_ONE;
                else       state_d = BUF_FULL;
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // Buffer entry movement, handshake flags and emitted-block counter.
    always_comb begin
        head_d     = head_q;
        head_err_d = head_err_q;
        tail_d     = tail_q;
        tail_err_d = tail_err_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push_s) begin
                    head_d     = result_s;
                    head_err_d = ~round_ok_s;
                end else begin
                    head_d     = head_q;
                end
            end
            BUF_ONE: begin
                if (push_s && pop_s) begin
                    head_d     = result_s;
                    head_err_d = ~round_ok_s;
                end else if (push_s) begin
                    tail_d     = result_s;
                    tail_err_d = ~round_ok_s;
                end else begin
                    head_d     = head_q;
                end
            end
            BUF_FULL: begin
                if (pop_s) begin
                    head_d     = tail_q;
                    head_err_d = tail_err_q;
                end else begin
                    head_d     = head_q;
                end
            end
            default: begin
                head_d     = head_q;
                head_err_d = head_err_q;
            end
        endcase
        in_ready_d  = (state_d != BUF_FULL);
        out_valid_d = (state_d != BUF_EMPTY);
        if (pop_s) begin
            blk_cnt_d = blk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            blk_cnt_d = blk_cnt_q;
        end
    end

    // State registers; reset clears keys, buffer and counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NKEYS; k++) begin
                keys_q[k] <= '0;
            end
            state_q     <= BUF_EMPTY;
            head_q      <= '0;
            head_err_q  <= 1'b0;
            tail_q      <= '0;
            tail_err_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            keys_q      <= keys_d;
            state_q     <= state_d;
            head_q      <= head_d;
            head_err_q  <= head_err_d;
            tail_q      <= tail_d;
            tail_err_q  <= tail_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = head_q;
    assign out_err   = head_err_q;
    assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_add_round_key_stream.sv
// Self-checking bench for add_round_key_stream: vector table plus hand-written
// back-pressure, collision, reset and counter-wrap sequences, checked by a scoreboard.
`timescale 1ns/1ps
module tb_add_round_key_stream;

    localparam int DW = 128;
    localparam int NK = 15;
    localparam int IW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_wr_en;
    logic [IW-1:0] key_wr_addr;
    logic [DW-1:0] key_wr_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_state;
    logic [IW-1:0] in_round;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_state;
    logic          out_err;
    logic [CW-1:0] blk_cnt;

    add_round_key_stream #(.DATA_W(DW), .NKEYS(NK), .IDX_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_round(in_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_err(out_err), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] st;
        logic          err;
    } exp_t;

    typedef struct {
        logic [DW-1:0] st;
        logic [IW-1:0] rnd;
        logic [DW-1:0] exp_st;
        logic          exp_err;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[9];
    int            tests_run = 0;
    int            fails = 0;
    logic [CW-1:0] exp_cnt;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests_run++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] kval(input int k);
        logic [7:0] b;
        logic [DW-1:0] fips_key;
        fips_key = 128'h000102030405060708090a0b0c0d0e0f;
        b = 8'(k) * 8'h1d ^ 8'ha5;
        if (k == 0) return fips_key;
        else        return {16{b}};
    endfunction

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            chk("blk_cnt", DW'(blk_cnt), DW'(exp_cnt));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL unexpected_out: got %h, expected no block", out_state);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_state", out_state, e.st);
                    chk("out_err", DW'(out_err), DW'(e.err));
                end
                exp_cnt = exp_cnt + 4'd1;
            end
        end
    end

    task automatic wr_key(input logic [IW-1:0] a, input logic [DW-1:0] d);
        key_wr_en   = 1'b1;
        key_wr_addr = a;
        key_wr_data = d;
        @(posedge clk); #1;
        key_wr_en   = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] st, input logic [IW-1:0] rnd,
                        input logic [DW-1:0] exp_st, input logic exp_err);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_state = st;
        in_round = rnd;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) begin
                sb.push_back('{exp_st, exp_err});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests_run++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0, expected accept within 50 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            tests_run++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        logic [DW-1:0] a_st, b_st, c_st, s_st, k1, k2;
        logic [CW-1:0] cnt0;

        rst = 1'b0; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
        in_valid = 1'b0; in_state = '0; in_round = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_state", out_state, '0);
        chk("rst_out_err", DW'(out_err), '0);
        chk("rst_blk_cnt", DW'(blk_cnt), '0);
        chk("rst_in_ready", DW'(in_ready), '0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", DW'(in_ready), DW'(1'b1));

        for (int k = 0; k < NK; k++) wr_key(IW'(k), kval(k));
        wr_key(4'd15, {4{32'h0badf00d}});

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 4'd0,
                    128'h00102030405060708090a0b0c0d0e0f0, 1'b0};
        vecs[1] = '{{4{32'hdeadbeef}}, 4'd1, '0, 1'b0};
        vecs[2] = '{{4{32'h01234567}}, 4'd7, '0, 1'b0};
        vecs[3] = '{{DW{1'b1}}, 4'd14, '0, 1'b0};
        vecs[4] = '{{DW{1'b0}}, 4'd3, '0, 1'b0};
        vecs[5] = '{{4{32'hcafef00d}}, 4'd15, {4{32'hcafef00d}}, 1'b1};
        vecs[6] = '{{4{32'h13579bdf}}, 4'd2, '0, 1'b0};
        vecs[7] = '{{4{32'h87654321}}, 4'd15, {4{32'h87654321}}, 1'b1};
        vecs[8] = '{{4{32'h0f1e2d3c}}, 4'd14, '0, 1'b0};
        for (int i = 1; i < 9; i++) begin
            if (vecs[i].rnd < 4'd15) vecs[i].exp_st = vecs[i].st ^ kval(int'(vecs[i].rnd));
        end
        for (int i = 0; i < 9; i++) send(vecs[i].st, vecs[i].rnd, vecs[i].exp_st, vecs[i].exp_err);
        drain();

        // Back-pressure: two blocks fill the buffer, third waits, order preserved.
        cnt0 = blk_cnt;
        a_st = {4{32'ha0a0a0a0}}; b_st = {4{32'hb1b1b1b1}}; c_st = {4{32'hc2c2c2c2}};
        out_ready = 1'b0;
        send(a_st, 4'd4, a_st ^ kval(4), 1'b0);
        send(b_st, 4'd6, b_st ^ kval(6), 1'b0);
        in_valid = 1'b1; in_state = c_st; in_round = 4'd8;
        chk("bp_in_ready_full", DW'(in_ready), '0);
        chk("bp_out_valid", DW'(out_valid), DW'(1'b1));
        chk("bp_head", out_state, a_st ^ kval(4));
        @(posedge clk); #1;
        chk("bp_stall_hold", out_state, a_st ^ kval(4));
        chk("bp_in_ready_hold", DW'(in_ready), '0);
        out_ready = 1'b1;
        send(c_st, 4'd8, c_st ^ kval(8), 1'b0);
        drain();
        chk("bp_blk_cnt", DW'(blk_cnt), DW'(cnt0 + 4'd3));

        // Same-cycle key write and accept on entry 5.
        k1 = {4{32'h11112222}}; k2 = {4{32'h33334444}}; s_st = {4{32'h5a5a5a5a}};
        wr_key(4'd5, k1);
        in_valid = 1'b1; in_state = s_st; in_round = 4'd5;
        key_wr_en = 1'b1; key_wr_addr = 4'd5; key_wr_data = k2;
        chk("col_in_ready", DW'(in_ready), DW'(1'b1));
        sb.push_back('{s_st ^ k1, 1'b0});
        @(posedge clk); #1;
        key_wr_en = 1'b0; in_valid = 1'b0;
        send(~s_st, 4'd5, ~s_st ^ k2, 1'b0);
        drain();

        // Reset with two blocks buffered.
        out_ready = 1'b0;
        send(a_st, 4'd1, a_st ^ kval(1), 1'b0);
        send(b_st, 4'd2, b_st ^ kval(2), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", DW'(out_valid), '0);
        chk("mid_rst_blk_cnt", DW'(blk_cnt), '0);
        chk("mid_rst_in_ready", DW'(in_ready), '0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_release_in_ready", DW'(in_ready), DW'(1'b1));

        // Counter wrap with zeroed keys: 17 blocks streamed back to back.
        for (int i = 0; i < 17; i++) begin
            logic [DW-1:0] st;
            st = {4{32'(i) * 32'h01010101 + 32'h10203040}};
            if (i > 0) chk("stream_in_ready", DW'(in_ready), DW'(1'b1));
            send(st, IW'(i % NK), st, 1'b0);
        end
        drain();
        chk("wrap_blk_cnt", DW'(blk_cnt), DW'(4'd1));

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
